// File: rtl/aud_adc_rx.sv
// I2S ADC receiver: synchronizes the codec serial port into clk, deserializes
// left/right words and buffers complete stereo frames in a first-word-fall-through FIFO.
`timescale 1ns/1ps
module aud_adc_rx #(
   parameter int unsigned SAMPLE_W   = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                aud_bclk,
   input  logic                aud_adclrck,
   input  logic                aud_adcdat,
   output logic [SAMPLE_W-1:0] sample_left,
   output logic [SAMPLE_W-1:0] sample_right,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overflow,
   output logic                frame_err,
   input  logic                err_clr
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BW = $clog2(SAMPLE_W + 1);
   localparam int unsigned FW = 2 * SAMPLE_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } state_t;

   // [0],[1] synchronizer stages, [2] history for edge detection
   logic [2:0]          bclk_sr;
   logic [2:0]          lr_sr;
   logic [1:0]          dat_sr;

   state_t              state;
   logic                chan;
   logic [BW-1:0]       bit_cnt;
   logic [SAMPLE_W-1:0] shreg;
   logic [SAMPLE_W-1:0] left_word;
   logic                left_ok;

   logic [FW-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;

   logic                bclk_rise_c;
   logic                lr_edge_c;
   logic                lr_fall_c;
   logic                dat_c;
   logic [SAMPLE_W-1:0] shift_next_c;
   logic                word_done_c;
   logic                push_c;
   logic [FW-1:0]       push_data_c;
   logic                short_err_c;
   logic                pop_c;
   logic                full_c;
   logic                push_ok_c;
   logic                drop_c;
   logic [AW-1:0]       rd_next_c;
   logic [AW-1:0]       wr_next_c;
   logic [CW-1:0]       count_next_c;
   logic [FW-1:0]       head_c;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Input synchronizers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_sr <= '0;
         lr_sr   <= '0;
         dat_sr  <= '0;
      end else begin
         bclk_sr <= {bclk_sr[1:0], aud_bclk};
         lr_sr   <= {lr_sr[1:0], aud_adclrck};
         dat_sr  <= {dat_sr[0], aud_adcdat};
      end
   end

   // Edge detection, deserializer next value and frame push decode
   always_comb begin
      bclk_rise_c  = bclk_sr[1] & ~bclk_sr[2];
      lr_edge_c    = lr_sr[1] ^ lr_sr[2];
      lr_fall_c    = ~lr_sr[1] & lr_sr[2];
      dat_c        = dat_sr[1];
      shift_next_c = (shreg << 1) | SAMPLE_W'(dat_c);
      word_done_c  = en && (state == SHIFT) && !lr_edge_c && bclk_rise_c &&
                     (bit_cnt == BW'(SAMPLE_W - 1));
      push_c       = word_done_c && chan && left_ok;
      push_data_c  = {left_word, shift_next_c};
      short_err_c  = en && (state == SHIFT) && lr_edge_c;
   end

   // Framing FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         chan      <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         left_word <= '0;
         left_ok   <= 1'b0;
      end else if (!en) begin
         state   <= IDLE;
         left_ok <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (lr_fall_c) begin
                  state   <= SKIP;
                  chan    <= 1'b0;
                  left_ok <= 1'b0;
               end
            end
            SKIP: begin
               if (bclk_rise_c) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  shreg   <= '0;
               end
            end
            SHIFT: begin
               // A channel ending early invalidates any held left word
               if (lr_edge_c) begin
                  state   <= SKIP;
                  chan    <= lr_sr[1];
                  left_ok <= 1'b0;
               end else if (bclk_rise_c) begin
                  shreg   <= shift_next_c;
                  bit_cnt <= bit_cnt + BW'(1);
                  if (word_done_c) begin
                     state <= PAD;
                     if (!chan) begin
                        left_word <= shift_next_c;
                        left_ok   <= 1'b1;
                     end else begin
                        left_ok   <= 1'b0;
                     end
                  end
               end
            end
            PAD: begin
               if (lr_edge_c) begin
                  state <= SKIP;
                  chan  <= lr_sr[1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO bookkeeping; head is precomputed so the outputs come straight from flops
   always_comb begin
      pop_c        = sample_valid & sample_ready;
      full_c       = (count == CW'(FIFO_DEPTH));
      push_ok_c    = push_c & (~full_c | pop_c);
      drop_c       = push_c & full_c & ~pop_c;
      rd_next_c    = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
      wr_next_c    = push_ok_c ? ptr_inc(wr_ptr) : wr_ptr;
      count_next_c = count + CW'(push_ok_c) - CW'(pop_c);
      head_c       = (push_ok_c && (wr_ptr == rd_next_c)) ? push_data_c : mem[rd_next_c];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         sample_valid <= 1'b0;
         sample_left  <= '0;
         sample_right <= '0;
      end else begin
         if (push_ok_c) mem[wr_ptr] <= push_data_c;
         wr_ptr       <= wr_next_c;
         rd_ptr       <= rd_next_c;
         count        <= count_next_c;
         sample_valid <= (count_next_c != '0);
         if (count_next_c != '0) begin
            sample_left  <= head_c[FW-1:SAMPLE_W];
            sample_right <= head_c[SAMPLE_W-1:0];
         end
      end
   end

   // Sticky error flags; a new event outranks a clear in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= drop_c | (overflow & ~err_clr);
         frame_err <= short_err_c | (frame_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_aud_adc_rx.sv
// Scoreboard bench for aud_adc_rx: an I2S codec model drives frames, a monitor
// pops expected frames whenever the consumer handshake completes.
`timescale 1ns/1ps
module tb_aud_adc_rx;

   localparam int unsigned SW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          aud_bclk = 1'b1;
   logic          aud_adclrck = 1'b1;
   logic          aud_adcdat = 1'b0;
   logic          sample_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic [SW-1:0] sample_left;
   logic [SW-1:0] sample_right;
   logic          sample_valid;
   logic          overflow;
   logic          frame_err;

   int              vectors = 0;
   int              miscompares = 0;
   logic [2*SW-1:0] sb[$];
   event            push_ev;
   int              cur_slot = -1;
   logic            cur_lvl = 1'b0;
   logic [2*SW-1:0] frames [6] = '{32'h0F0F_F0F0, 32'h8001_7FFE, 32'h1234_5678,
                                   32'hFFFF_0000, 32'h0001_8000, 32'hDEAD_BEEF};

   aud_adc_rx #(.SAMPLE_W(SW), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (en),
      .aud_bclk     (aud_bclk),
      .aud_adclrck  (aud_adclrck),
      .aud_adcdat   (aud_adcdat),
      .sample_left  (sample_left),
      .sample_right (sample_right),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overflow     (overflow),
      .frame_err    (frame_err),
      .err_clr      (err_clr)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One I2S channel: slot 0 carries the LRCK change, MSB lands in slot 1
   task automatic send_channel(input logic lvl, input logic [SW-1:0] w, input int nslots);
      @(negedge clk);
      for (int s = 0; s < nslots; s++) begin
         aud_bclk = 1'b0;
         if (s == 0) aud_adclrck = lvl;
         aud_adcdat = (s >= 1 && s <= int'(SW)) ? w[int'(SW) - s] : 1'b0;
         cur_lvl  = lvl;
         cur_slot = s;
         #160;
         aud_bclk = 1'b1;
         if (lvl && s == int'(SW)) -> push_ev;
         #160;
      end
   endtask

   task automatic send_frame(input logic [2*SW-1:0] f);
      send_channel(1'b0, f[2*SW-1:SW], 32);
      send_channel(1'b1, f[SW-1:0], 32);
   endtask

   // Monitor: every completed handshake must match the oldest expected frame
   initial begin
      logic [2*SW-1:0] exp_v;
      forever begin
         @(negedge clk);
         if (reset_n && sample_valid && sample_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_frame: got %h_%h, required none", sample_left, sample_right);
            end else begin
               exp_v = sb.pop_front();
               if ({sample_left, sample_right} !== exp_v) begin
                  miscompares++;
                  $display("FAIL frame: got %h_%h, required %h_%h", sample_left, sample_right,
                           exp_v[2*SW-1:SW], exp_v[SW-1:0]);
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      chk("rst_valid", 64'(sample_valid), 0);
      chk("rst_left", 64'(sample_left), 0);
      chk("rst_right", 64'(sample_right), 0);
      chk("rst_ovf", 64'(overflow), 0);
      chk("rst_ferr", 64'(frame_err), 0);
      reset_n = 1'b1;
      en = 1'b1;
      sample_ready = 1'b1;
      idle(5);

      // Basic frame
      sb.push_back({16'hA5C3, 16'h3C5A});
      send_frame({16'hA5C3, 16'h3C5A});
      idle(20);
      chk("basic_drain", 64'(sb.size()), 0);
      chk("basic_ovf", 64'(overflow), 0);
      chk("basic_ferr", 64'(frame_err), 0);

      // Enable mid right channel: first frame is the next full pair
      en = 1'b0;
      idle(5);
      fork
         send_channel(1'b1, 16'h7777, 32);
         begin idle(100); en = 1'b1; end
      join
      sb.push_back({16'h2468, 16'hACE1});
      send_frame({16'h2468, 16'hACE1});
      idle(20);
      chk("midstart_drain", 64'(sb.size()), 0);
      chk("midstart_ferr", 64'(frame_err), 0);

      // Short left channel (10 bits)
      send_channel(1'b0, 16'h1234, 11);
      send_channel(1'b1, 16'hFFFF, 32);
      idle(5);
      chk("short_ferr", 64'(frame_err), 1);
      chk("short_nopush", 64'(sample_valid), 0);
      sb.push_back({16'h5A5A, 16'h0FF0});
      send_frame({16'h5A5A, 16'h0FF0});
      idle(20);
      chk("short_next_drain", 64'(sb.size()), 0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      idle(1);
      chk("short_clr_ferr", 64'(frame_err), 0);
      chk("short_ovf", 64'(overflow), 0);

      // Overflow: 6 frames into depth 4
      sample_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) sb.push_back(frames[i]);
         send_frame(frames[i]);
         idle(5);
         if (i == 3) begin
            chk("ovf_before", 64'(overflow), 0);
            chk("ovf_head_l", 64'(sample_left), 64'(frames[0][2*SW-1:SW]));
            chk("ovf_head_r", 64'(sample_right), 64'(frames[0][SW-1:0]));
         end
         if (i == 4) chk("ovf_after5", 64'(overflow), 1);
      end
      sample_ready = 1'b1;
      idle(20);
      chk("ovf_drain", 64'(sb.size()), 0);
      chk("ovf_empty", 64'(sample_valid), 0);
      chk("ovf_sticky", 64'(overflow), 1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      idle(1);
      chk("ovf_clr", 64'(overflow), 0);

      // Push and pop together while full
      sample_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(frames[i]);
         send_frame(frames[i]);
      end
      sb.push_back(frames[5]);
      fork
         send_frame(frames[5]);
         begin
            @(push_ev);
            @(posedge clk);
            @(posedge clk);
            #1 sample_ready = 1'b1;
            @(posedge clk);
            #1 sample_ready = 1'b0;
         end
      join
      idle(5);
      chk("full_pp_ovf", 64'(overflow), 0);
      chk("full_pp_valid", 64'(sample_valid), 1);
      chk("full_pp_head", 64'({sample_left, sample_right}), 64'(frames[1]));
      chk("full_pp_queued", 64'(sb.size()), 4);
      sample_ready = 1'b1;
      idle(20);
      chk("full_pp_drain", 64'(sb.size()), 0);
      chk("full_pp_empty", 64'(sample_valid), 0);

      // Reset during bit 8 of the right channel
      sample_ready = 1'b0;
      sb.push_back(frames[2]);
      send_frame(frames[2]);
      idle(5);
      chk("prerst_valid", 64'(sample_valid), 1);
      cur_slot = -1;
      fork
         send_frame(frames[3]);
         begin
            wait (cur_lvl == 1'b1 && cur_slot == 8);
            #5 reset_n = 1'b0;
            sb.delete();
            #1;
            chk("rst2_valid", 64'(sample_valid), 0);
            chk("rst2_left", 64'(sample_left), 0);
            chk("rst2_right", 64'(sample_right), 0);
            chk("rst2_flags", 64'({overflow, frame_err}), 0);
            repeat (3) @(posedge clk);
            #1 reset_n = 1'b1;
         end
      join
      idle(20);
      chk("rst2_nopush", 64'(sample_valid), 0);
      sample_ready = 1'b1;
      sb.push_back(frames[4]);
      send_frame(frames[4]);
      idle(20);
      chk("rst2_next_drain", 64'(sb.size()), 0);
      chk("rst2_ferr", 64'(frame_err), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
